box_draw_engine: RTL
====================

Name: box_draw_engine

Overview:
- Pixel-stream generator that sits directly upstream of vga_adapter and drives its x/y/colour/plot inputs.
- Accepts a box request (top-left position and colour) from the animation/position logic. Erases the previously drawn box in the background colour, then draws the new box, one pixel per clock.
- Signals completion with a one-cycle done pulse so the requester can issue the next frame's position.

Parameters:
- BOX_W, 4, box width in pixels (1..16)
- BOX_H, 4, box height in pixels (1..16)
- X_MAX, 159, last visible column
- Y_MAX, 119, last visible row
- BG_COLOUR, 3'b000, colour used for erase

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- resetn  in  1  asynchronous, active-low reset
- start  in  1  request strobe; accepted only when ready=1
- x_in  in  8  requested box left column
- y_in  in  7  requested box top row
- colour_in  in  3  requested box colour
- ready  out  1  engine idle, start will be accepted
- done  out  1  one-cycle pulse, request fully plotted
- x_out  out  8  pixel column to vga_adapter
- y_out  out  7  pixel row to vga_adapter
- colour_out  out  3  pixel colour to vga_adapter
- plot  out  1  write strobe to vga_adapter

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (resetn). All state registers clear immediately on resetn=0.
- Reset values:
  - state=IDLE, have_prev=0, cx=cy=0, all latched positions/colour 0.
  - Outputs: ready=1, done=0, plot=0, x_out=0, y_out=0, colour_out=0.
- States: IDLE, ERASE, DRAW, DONE. Outputs are Moore, decoded from registers.
- IDLE:
  - ready=1, plot=0.
  - On the edge where start=1: latch x_in/y_in/colour_in into new_x/new_y/new_col and clear cx, cy.
  - Next state is ERASE if have_prev=1, else DRAW.
- ERASE:
  - Pixel = (old_x+cx, old_y+cy), colour_out=BG_COLOUR.
  - cx counts 0..BOX_W-1. On wrap, cx=0 and cy increments. Raster order, x fastest.
  - After pixel (BOX_W-1, BOX_H-1): go to DRAW with cx=cy=0.
- DRAW:
  - Same scan over (new_x+cx, new_y+cy), colour_out=new_col.
  - After the last pixel: go to DONE. Copy new_x/new_y into old_x/old_y and set have_prev=1.
- DONE:
  - done=1 for exactly one cycle, plot=0, ready=0.
  - Always returns to IDLE.
- Clipping:
  - Sums are formed at 9 bits (x) and 8 bits (y).
  - If sum_x>X_MAX or sum_y>Y_MAX, plot=0 for that cycle. The counter still advances, so the cycle count is fixed regardless of clipping.
  - x_out/y_out are the truncated sums.
- Latency:
  - Accept at edge k; first pixel is presented in cycle k+1.
  - Without erase: done is high in cycle k+1+BOX_W*BOX_H.
  - With erase: done is high in cycle k+1+2*BOX_W*BOX_H.
- Handshake:
  - start while ready=0 is ignored, with no queuing.
  - start held continuously is accepted once per IDLE visit.
  - Minimum spacing between back-to-back requests is 1 IDLE cycle.
  - x_in/y_in/colour_in are sampled only at acceptance; later changes have no effect.
- Reset mid-operation:
  - plot drops to 0 asynchronously and the stream is abandoned.
  - have_prev=0, so the next request draws without erase.

Test Plan:
1. Reset, then start with x=10, y=20, colour=101 → no erase; 16 plot cycles covering (10..13, 20..23), x fastest, colour 101; done pulses in the 17th cycle after accept; ready=1 the following cycle.
2. Follow with x=11, y=20, colour=010 → 16 cycles at (10..13, 20..23) colour 000, then 16 cycles at (11..14, 20..23) colour 010; done in the 33rd cycle after accept.
3. Request x=158, y=118 → exactly 4 pixels plotted, (158..159, 118..119); the other 12 cycles have plot=0; done still at cycle 17 (have_prev=0) or 33.
4. Pulse start during DRAW and during DONE with x=50 → ignored, and the box is drawn at the original coordinates; start held high through DONE is accepted in the next IDLE cycle.
5. Assert resetn=0 while DRAW is on pixel 7 → plot=0 and ready=1 without waiting for a clock edge; after release, a request at x=0, y=0 produces only 16 draw cycles, with no erase.
6. Change x_in/colour_in every cycle after acceptance → plotted coordinates and colour match the values sampled at acceptance.

Source files
------------

// File: rtl/box_draw_engine.sv
// Box pixel-stream generator for vga_adapter: erases the previous box in the
// background colour, then draws the new box, one pixel per clock.
module box_draw_engine #(
  parameter int         BOX_W     = 4,
  parameter int         BOX_H     = 4,
  parameter int         X_MAX     = 159,
  parameter int         Y_MAX     = 119,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] colour_in,
  output logic       ready,
  output logic       done,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_r, state_s;
  logic       have_prev_r, have_prev_s;
  logic [4:0] cx_r, cx_s, cy_r, cy_s;
  logic [7:0] new_x_r, new_x_s, old_x_r, old_x_s;
  logic [6:0] new_y_r, new_y_s, old_y_r, old_y_s;
  logic [2:0] new_col_r, new_col_s;

  logic       ready_s, done_s, plot_s;
  logic [7:0] x_out_s, base_x_s;
  logic [6:0] y_out_s, base_y_s;
  logic [2:0] colour_s;
  logic [8:0] sum_x_s;
  logic [7:0] sum_y_s;

  // Next-state logic: request capture and raster scan counters
  always_comb begin
    state_s     = state_r;
    have_prev_s = have_prev_r;
    cx_s        = cx_r;
    cy_s        = cy_r;
    new_x_s     = new_x_r;
    new_y_s     = new_y_r;
    new_col_s   = new_col_r;
    old_x_s     = old_x_r;
    old_y_s     = old_y_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          new_x_s   = x_in;
          new_y_s   = y_in;
          new_col_s = colour_in;
          cx_s      = 5'd0;
          cy_s      = 5'd0;
          state_s   = have_prev_r ? ERASE : DRAW;
        end else begin
          state_s = IDLE;
        end
      end
      ERASE, DRAW: begin
        if (cx_r == 5'(BOX_W - 1)) begin
          cx_s = 5'd0;
          if (cy_r == 5'(BOX_H - 1)) begin
            cy_s = 5'd0;
            if (state_r == ERASE) begin
              state_s = DRAW;
            end else begin
              // New box becomes the one to erase on the next request
              state_s     = DONE;
              old_x_s     = new_x_r;
              old_y_s     = new_y_r;
              have_prev_s = 1'b1;
            end
          end else begin
            cy_s = cy_r + 5'd1;
          end
        end else begin
          cx_s = cx_r + 5'd1;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode from next-state values so the outputs themselves are registers
  always_comb begin
    base_x_s = (state_s == ERASE) ? old_x_s : new_x_s;
    base_y_s = (state_s == ERASE) ? old_y_s : new_y_s;
    sum_x_s  = {1'b0, base_x_s} + {4'b0000, cx_s};
    sum_y_s  = {1'b0, base_y_s} + {3'b000, cy_s};
    ready_s  = 1'b0;
    done_s   = 1'b0;
    plot_s   = 1'b0;
    x_out_s  = 8'd0;
    y_out_s  = 7'd0;
    colour_s = 3'b000;
    case (state_s)
      IDLE: ready_s = 1'b1;
      DONE: done_s  = 1'b1;
      ERASE, DRAW: begin
        x_out_s  = sum_x_s[7:0];
        y_out_s  = sum_y_s[6:0];
        colour_s = (state_s == ERASE) ? BG_COLOUR : new_col_s;
        plot_s   = (sum_x_s <= 9'(X_MAX)) && (sum_y_s <= 8'(Y_MAX));
      end
      default: ready_s = 1'b0;
    endcase
  end

  // State, scan and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= IDLE;
      have_prev_r <= 1'b0;
      cx_r        <= 5'd0;
      cy_r        <= 5'd0;
      new_x_r     <= 8'd0;
      new_y_r     <= 7'd0;
      new_col_r   <= 3'b000;
      old_x_r     <= 8'd0;
      old_y_r     <= 7'd0;
      ready       <= 1'b1;
      done        <= 1'b0;
      plot        <= 1'b0;
      x_out       <= 8'd0;
      y_out       <= 7'd0;
      colour_out  <= 3'b000;
    end else begin
      state_r     <= state_s;
      have_prev_r <= have_prev_s;
      cx_r        <= cx_s;
      cy_r        <= cy_s;
      new_x_r     <= new_x_s;
      new_y_r     <= new_y_s;
      new_col_r   <= new_col_s;
      old_x_r     <= old_x_s;
      old_y_r     <= old_y_s;
      ready       <= ready_s;
      done        <= done_s;
      plot        <= plot_s;
      x_out       <= x_out_s;
      y_out       <= y_out_s;
      colour_out  <= colour_s;
    end
  end

endmodule
